// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg: opcodes, command/state enums and per-command frame geometry.
package cmd_frame_pkg;
    localparam logic [7:0] OP_WR     = 8'hAA;
    localparam logic [7:0] OP_RD     = 8'hBB;
    localparam logic [7:0] OP_ALU_AB = 8'hCC;
    localparam logic [7:0] OP_ALU    = 8'hDD;

    typedef enum logic [1:0] {CMD_WR, CMD_RD, CMD_ALU_AB, CMD_ALU} cmd_type_e;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_e;

    function automatic logic [2:0] frame_len(cmd_type_e t);
        return t == CMD_ALU_AB ? 3'd4 : t == CMD_WR ? 3'd3 : 3'd2;
    endfunction

    function automatic logic [1:0] rsp_len(cmd_type_e t);
        return t == CMD_WR ? 2'd0 : t == CMD_RD ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [7:0] opcode(cmd_type_e t);
        return t == CMD_WR ? OP_WR : t == CMD_RD ? OP_RD : t == CMD_ALU_AB ? OP_ALU_AB : OP_ALU;
    endfunction
endpackage

// File: rtl/cmd_frame_master_if.sv
// cmd_frame_master_if: command request, UART TX/RX byte paths and response bundle.
interface cmd_frame_master_if #(parameter int BYTE = 8);
    logic            CMD_VLD;
    logic [1:0]      CMD_TYPE;
    logic [3:0]      CMD_ADDR;
    logic [BYTE-1:0] CMD_DATA_A;
    logic [BYTE-1:0] CMD_DATA_B;
    logic [3:0]      CMD_FUN;
    logic            CMD_BUSY;
    logic [BYTE-1:0] TX_P_DATA;
    logic            TX_D_VLD;
    logic            TX_BUSY;
    logic [BYTE-1:0] RX_P_DATA;
    logic            RX_D_VLD;
    logic [2*BYTE-1:0] RSP_DATA;
    logic            RSP_VLD;
    logic            RSP_TIMEOUT;

    modport master (
        input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA_A, CMD_DATA_B, CMD_FUN, TX_BUSY, RX_P_DATA, RX_D_VLD,
        output CMD_BUSY, TX_P_DATA, TX_D_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT
    );

    modport slave (
        output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA_A, CMD_DATA_B, CMD_FUN, TX_BUSY, RX_P_DATA, RX_D_VLD,
        input  CMD_BUSY, TX_P_DATA, TX_D_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT
    );
endinterface

// File: rtl/cmd_frame_master_rsp_timer.sv
// rsp_timer: saturating inter-byte timer; o_expire holds once TIMEOUT_CYC-1 is reached.
module rsp_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && r_cnt != LAST)
            r_cnt <= r_cnt + 1'b1;

    assign o_expire = r_cnt == LAST;
endmodule

// File: rtl/cmd_frame_master.sv
// cmd_frame_master: serialises one command into a UART byte frame and collects its response.
module cmd_frame_master
    import cmd_frame_pkg::*;
#(
    parameter int BYTE        = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic CLK,
    input  logic RST,
    cmd_frame_master_if.master bus
);
    state_e          r_state, w_next;
    cmd_type_e       r_type;
    logic [3:0]      r_addr;
    logic [3:0]      r_fun;
    logic [BYTE-1:0] r_a;
    logic [BYTE-1:0] r_b;
    logic [1:0]      r_idx;
    logic            r_rcnt;
    logic [BYTE-1:0] r_lo;
    logic [2*BYTE-1:0] r_rsp;
    logic [BYTE-1:0] w_byte;
    logic            w_accept, w_tx_acc, w_last_tx, w_rx, w_last_rx, w_expire, w_tmo;

    assign w_accept  = bus.CMD_VLD && r_state == IDLE;
    assign w_tx_acc  = r_state == SEND && !bus.TX_BUSY;
    assign w_last_tx = w_tx_acc && {1'b0, r_idx} == frame_len(r_type) - 3'd1;
    assign w_rx      = r_state == WAIT_RSP && bus.RX_D_VLD;
    assign w_last_rx = w_rx && (r_rcnt || rsp_len(r_type) == 2'd1);
    // An arriving byte always beats expiry on the same cycle
    assign w_tmo     = r_state == WAIT_RSP && w_expire && !bus.RX_D_VLD;

    assign w_byte = r_idx == 2'd0 ? BYTE'(opcode(r_type)) :
                    r_idx == 2'd1 ? (r_type == CMD_ALU_AB ? r_a : r_type == CMD_ALU ? BYTE'(r_fun) : BYTE'(r_addr)) :
                    r_idx == 2'd2 ? (r_type == CMD_ALU_AB ? r_b : r_a) :
                    BYTE'(r_fun);

    always_ff @(posedge CLK or posedge RST)
        if (RST)
            r_state <= IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     w_next = w_accept ? SEND : IDLE;
            SEND:     w_next = !w_last_tx ? SEND : rsp_len(r_type) == 2'd0 ? DONE : WAIT_RSP;
            WAIT_RSP: w_next = w_last_rx ? DONE : w_tmo ? IDLE : WAIT_RSP;
            DONE:     w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            r_type <= CMD_WR;
            r_addr <= '0;
            r_fun  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= '0;
            r_rcnt <= 1'b0;
            r_lo   <= '0;
            r_rsp  <= '0;
        end else begin
            if (w_accept) begin
                r_type <= cmd_type_e'(bus.CMD_TYPE);
                r_addr <= bus.CMD_ADDR;
                r_fun  <= bus.CMD_FUN;
                r_a    <= bus.CMD_DATA_A;
                r_b    <= bus.CMD_DATA_B;
                r_idx  <= '0;
                r_rcnt <= 1'b0;
            end
            if (w_tx_acc)
                r_idx <= r_idx + 2'd1;
            if (w_rx) begin
                r_lo   <= bus.RX_P_DATA;
                r_rcnt <= 1'b1;
            end
            // Result register only changes on completion so a timeout leaves it intact
            if (w_last_rx)
                r_rsp <= r_rcnt ? {bus.RX_P_DATA, r_lo} : {BYTE'(0), bus.RX_P_DATA};
            if (w_last_tx && rsp_len(r_type) == 2'd0)
                r_rsp <= '0;
        end

    rsp_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .i_clr    (r_state != WAIT_RSP || bus.RX_D_VLD),
        .i_en     (r_state == WAIT_RSP),
        .o_expire (w_expire)
    );

    assign bus.CMD_BUSY    = r_state != IDLE;
    assign bus.TX_D_VLD    = r_state == SEND;
    assign bus.TX_P_DATA   = r_state == SEND ? w_byte : '0;
    assign bus.RSP_DATA    = r_rsp;
    assign bus.RSP_VLD     = r_state == DONE;
    assign bus.RSP_TIMEOUT = w_tmo;
endmodule

// File: tb/tb_cmd_frame_master.sv
// tb_cmd_frame_master: directed command vectors plus stall, timeout and reset corner sequences.
module tb_cmd_frame_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cmd_frame_master_if #(.BYTE(8)) bus ();

    cmd_frame_master #(.BYTE(8), .TIMEOUT_CYC(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  typ;
        logic [3:0]  addr;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  fun;
        int          ntx;
        logic [31:0] tx;
        int          nrx;
        logic [15:0] rx;
        logic [15:0] rsp;
    } vec_t;

    vec_t vecs[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, 32'(bus.CMD_BUSY), 0);
        check({tag, " tx_vld"}, 32'(bus.TX_D_VLD), 0);
        check({tag, " tx_data"}, 32'(bus.TX_P_DATA), 0);
        check({tag, " rsp_data"}, 32'(bus.RSP_DATA), 0);
        check({tag, " rsp_vld"}, 32'(bus.RSP_VLD), 0);
        check({tag, " rsp_tmo"}, 32'(bus.RSP_TIMEOUT), 0);
    endtask

    task automatic issue(input logic [1:0] typ, input logic [3:0] addr, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] fun);
        bus.CMD_TYPE   = typ;
        bus.CMD_ADDR   = addr;
        bus.CMD_DATA_A = a;
        bus.CMD_DATA_B = b;
        bus.CMD_FUN    = fun;
        bus.CMD_VLD    = 1'b1;
        tick();
        bus.CMD_VLD    = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        bus.RX_P_DATA = d;
        bus.RX_D_VLD  = 1'b1;
        tick();
        bus.RX_D_VLD  = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        logic [31:0] t;
        logic [15:0] r;
        t = v.tx;
        r = v.rx;
        issue(v.typ, v.addr, v.a, v.b, v.fun);
        for (int i = 0; i < v.ntx; i++) begin
            check({tag, " tx_vld"}, 32'(bus.TX_D_VLD), 1);
            check({tag, " tx_byte"}, 32'(bus.TX_P_DATA), 32'(t[31-8*i -: 8]));
            tick();
        end
        for (int i = 0; i < v.nrx; i++) begin
            check({tag, " wait tx_vld"}, 32'(bus.TX_D_VLD), 0);
            check({tag, " early rsp_vld"}, 32'(bus.RSP_VLD), 0);
            rx_pulse(r[15-8*i -: 8]);
            if (i == 0 && v.nrx == 2) begin
                tick();
                tick();
            end
        end
        check({tag, " rsp_vld"}, 32'(bus.RSP_VLD), 1);
        check({tag, " rsp_data"}, 32'(bus.RSP_DATA), 32'(v.rsp));
        tick();
        check({tag, " rsp_vld pulse"}, 32'(bus.RSP_VLD), 0);
        check({tag, " busy end"}, 32'(bus.CMD_BUSY), 0);
        check({tag, " rsp_data hold"}, 32'(bus.RSP_DATA), 32'(v.rsp));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        int   n;
        vecs[0] = '{2'd0, 4'h5, 8'h3C, 8'h77, 4'h3, 3, 32'hAA053C00, 0, 16'h0000, 16'h0000};
        vecs[1] = '{2'd1, 4'h2, 8'h5A, 8'h00, 4'h9, 2, 32'hBB020000, 1, 16'h7E00, 16'h007E};
        vecs[2] = '{2'd2, 4'h0, 8'h12, 8'h34, 4'h2, 4, 32'hCC123402, 2, 16'h4803, 16'h0348};
        vecs[3] = '{2'd3, 4'h6, 8'h11, 8'h00, 4'h1, 2, 32'hDD010000, 2, 16'h55AA, 16'hAA55};
        vecs[4] = '{2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 2, 32'hBB0F0000, 1, 16'hFFEE, 16'h00FF};
        vecs[5] = '{2'd0, 4'h0, 8'hFF, 8'h00, 4'h0, 3, 32'hAA00FF00, 0, 16'h0000, 16'h0000};
        vecs[6] = '{2'd2, 4'h0, 8'hFF, 8'h00, 4'hF, 4, 32'hCCFF000F, 2, 16'h0180, 16'h8001};

        bus.CMD_VLD = 0; bus.CMD_TYPE = 0; bus.CMD_ADDR = 0; bus.CMD_DATA_A = 0;
        bus.CMD_DATA_B = 0; bus.CMD_FUN = 0; bus.TX_BUSY = 0; bus.RX_P_DATA = 0; bus.RX_D_VLD = 0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++)
            run_cmd(vecs[k], $sformatf("vec%0d", k));

        // read with TX stall on byte 1, a stray command and a stray RX byte during SEND
        issue(2'd1, 4'h2, 8'h00, 8'h00, 4'h0);
        check("stall byte0", 32'(bus.TX_P_DATA), 32'hBB);
        tick();
        bus.TX_BUSY = 1'b1;
        bus.CMD_VLD = 1'b1; bus.CMD_TYPE = 2'd0; bus.CMD_ADDR = 4'h9;
        for (int k = 0; k < 3; k++) begin
            check("stall tx_vld", 32'(bus.TX_D_VLD), 1);
            check("stall tx_byte", 32'(bus.TX_P_DATA), 32'h02);
            bus.RX_P_DATA = 8'h99;
            bus.RX_D_VLD  = (k == 1);
            tick();
        end
        bus.RX_D_VLD = 1'b0; bus.CMD_VLD = 1'b0; bus.TX_BUSY = 1'b0;
        check("stall release byte", 32'(bus.TX_P_DATA), 32'h02);
        tick();
        check("stall wait tx_vld", 32'(bus.TX_D_VLD), 0);
        check("stall wait rsp_vld", 32'(bus.RSP_VLD), 0);
        check("stall wait busy", 32'(bus.CMD_BUSY), 1);
        rx_pulse(8'h7E);
        check("stall rsp_vld", 32'(bus.RSP_VLD), 1);
        check("stall rsp_data", 32'(bus.RSP_DATA), 32'h007E);
        tick();
        check("stall rsp_vld pulse", 32'(bus.RSP_VLD), 0);
        rx_pulse(8'h55);
        check("extra rx busy", 32'(bus.CMD_BUSY), 0);
        check("extra rx rsp_vld", 32'(bus.RSP_VLD), 0);
        check("extra rx rsp_data", 32'(bus.RSP_DATA), 32'h007E);

        // alu_fun timeout after one response byte
        issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h1);
        check("tmo byte0", 32'(bus.TX_P_DATA), 32'hDD);
        tick();
        check("tmo byte1", 32'(bus.TX_P_DATA), 32'h01);
        tick();
        rx_pulse(8'h10);
        seen = 1'b0;
        n = 0;
        while (!bus.RSP_TIMEOUT && n < 40) begin
            seen |= bus.RSP_VLD;
            tick();
            n++;
        end
        check("tmo cycles after byte", 32'(n + 1), 16);
        check("tmo pulse", 32'(bus.RSP_TIMEOUT), 1);
        check("tmo no rsp_vld", 32'(seen | bus.RSP_VLD), 0);
        check("tmo rsp_data kept", 32'(bus.RSP_DATA), 32'h007E);
        tick();
        check("tmo pulse width", 32'(bus.RSP_TIMEOUT), 0);
        check("tmo busy", 32'(bus.CMD_BUSY), 0);
        check("tmo rsp_vld", 32'(bus.RSP_VLD), 0);

        // final byte lands on the expiry cycle
        issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h7);
        check("race byte1", 32'(bus.TX_P_DATA), 32'hDD);
        tick();
        check("race byte2", 32'(bus.TX_P_DATA), 32'h07);
        tick();
        rx_pulse(8'h21);
        for (int k = 0; k < 15; k++) tick();
        check("race expiry reached", 32'(bus.RSP_TIMEOUT), 1);
        bus.RX_P_DATA = 8'h43;
        bus.RX_D_VLD  = 1'b1;
        #1;
        check("race byte wins", 32'(bus.RSP_TIMEOUT), 0);
        tick();
        bus.RX_D_VLD = 1'b0;
        check("race rsp_vld", 32'(bus.RSP_VLD), 1);
        check("race rsp_data", 32'(bus.RSP_DATA), 32'h4321);
        tick();
        check("race busy", 32'(bus.CMD_BUSY), 0);
        check("race tmo", 32'(bus.RSP_TIMEOUT), 0);

        // asynchronous reset while waiting for a read response
        issue(2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
        tick();
        tick();
        tick();
        check("rst pre busy", 32'(bus.CMD_BUSY), 1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        tick();
        rst = 1'b0;
        rx_pulse(8'h66);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            seen |= bus.RSP_VLD | bus.RSP_TIMEOUT | bus.CMD_BUSY;
            tick();
        end
        check("post rst silent", 32'(seen), 0);
        run_cmd(vecs[2], "after rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cmd_frame_master.md
Name: cmd_frame_master

Overview:
- Host-side initiator for the serial command protocol. It turns one command request into the byte frame that the system controller decodes: write 0xAA, read 0xBB, ALU-with-operands 0xCC, ALU-only 0xDD.
- Streams the frame into the UART TX byte path, then collects the response bytes from the UART RX byte path.
- Presents the assembled result or a timeout. Used in the host bridge and as the bench-side driver for full-system tests.

Parameters:
- BYTE, 8, data byte width.
- TIMEOUT_CYC, 4096, CLK cycles allowed between response bytes before the request is abandoned.

Ports:
- CLK  in  1  single clock.
- RST  in  1  asynchronous, active-high reset.
- CMD_VLD  in  1  request strobe; accepted when CMD_VLD && !CMD_BUSY.
- CMD_TYPE  in  2  0=write, 1=read, 2=alu_ab, 3=alu_fun.
- CMD_ADDR  in  4  register address (write/read).
- CMD_DATA_A  in  BYTE  write data, or operand A.
- CMD_DATA_B  in  BYTE  operand B.
- CMD_FUN  in  4  ALU function code.
- CMD_BUSY  out  1  high whenever state != IDLE.
- TX_P_DATA  out  BYTE  frame byte to the UART TX path.
- TX_D_VLD  out  1  frame byte valid; held until accepted.
- TX_BUSY  in  1  TX path stall; a byte is accepted on a cycle with TX_D_VLD && !TX_BUSY.
- RX_P_DATA  in  BYTE  response byte.
- RX_D_VLD  in  1  single-cycle pulse per response byte.
- RSP_DATA  out  2*BYTE  assembled result; held until the next request completes.
- RSP_VLD  out  1  one-cycle completion pulse.
- RSP_TIMEOUT  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (RST=1, asynchronous): state IDLE. All outputs 0: TX_P_DATA, TX_D_VLD, CMD_BUSY, RSP_DATA, RSP_VLD, RSP_TIMEOUT. Byte index and timer cleared.
- Reset mid-frame or mid-wait: the in-flight command is abandoned silently; no RSP_VLD and no RSP_TIMEOUT.
- Command capture: on accept in IDLE, all CMD_* fields are registered. CMD_* is ignored while CMD_BUSY=1.
- Frame contents (nibble fields zero-extended to BYTE):
  - write: AA, {0,ADDR}, DATA_A — 3 bytes, 0 response bytes.
  - read: BB, {0,ADDR} — 2 bytes, 1 response byte.
  - alu_ab: CC, DATA_A, DATA_B, {0,FUN} — 4 bytes, 2 response bytes.
  - alu_fun: DD, {0,FUN} — 2 bytes, 2 response bytes.
- States:
  - IDLE: on accept, go to SEND with byte index 0.
  - SEND: TX_D_VLD=1 with TX_P_DATA = frame[idx]. On a TX accept, idx increments. After the last byte is accepted:
    - response count = 0: go to DONE;
    - otherwise: go to WAIT_RSP with timer = 0.
  - WAIT_RSP: each RX_D_VLD stores a byte and clears the timer.
    - Bytes are stored LSB first: byte0 -> RSP_DATA[7:0], byte1 -> RSP_DATA[15:8].
    - Read result: upper byte forced to 0.
    - When the expected count is reached, go to DONE.
    - If the timer reaches TIMEOUT_CYC-1 with no byte that cycle: RSP_TIMEOUT=1 for one cycle, go to IDLE. RSP_DATA keeps its previous value.
  - DONE: RSP_VLD=1 for exactly one cycle, then go to IDLE. Write completes with RSP_DATA = 0.
- Latency:
  - First TX_D_VLD appears on the cycle after command accept.
  - Back-to-back bytes with TX_BUSY=0 give one byte per cycle.
  - RSP_VLD appears one cycle after the final RX byte (or after the final TX accept for a write).
- TX_P_DATA must be stable while TX_D_VLD=1 and TX_BUSY=1. TX_D_VLD is never dropped before acceptance.
- RX_D_VLD in IDLE or SEND is ignored; it is not counted.
- Timeout expiry and RX_D_VLD on the same cycle: the byte wins and the timer clears.
- Extra RX bytes after completion are ignored.
- Timer width is clog2(TIMEOUT_CYC). The timer saturates; it never wraps.

Decomposition:
- Package cmd_frame_pkg:
  - opcode constants OP_WR=8'hAA, OP_RD=8'hBB, OP_ALU_AB=8'hCC, OP_ALU=8'hDD;
  - cmd_type_e enum;
  - state_e enum {IDLE, SEND, WAIT_RSP, DONE};
  - per-type frame-length and response-length constant functions.
- Sub-module rsp_timer: clear/enable/expire counter parameterised by TIMEOUT_CYC.

Test Plan:
- Write, type 0, ADDR=5, DATA_A=0x3C, TX_BUSY=0 -> TX bytes AA,05,3C on 3 consecutive cycles; RSP_VLD one cycle after the last accept; RSP_DATA=0x0000.
- Read, type 1, ADDR=2, TX_BUSY high for 3 cycles during byte 1 -> byte 1 (0x02) held stable until accepted; RX 0x7E -> RSP_DATA=0x007E, single RSP_VLD pulse.
- alu_ab, type 2, A=0x12, B=0x34, FUN=2 -> TX CC,12,34,02; RX 0x48 then 0x03 -> RSP_DATA=0x0348.
- Timeout: alu_fun, type 3, FUN=1, TIMEOUT_CYC=16, RX 0x10 then silence -> RSP_TIMEOUT exactly 16 cycles after the byte; no RSP_VLD; CMD_BUSY falls.
- Robustness: CMD_VLD while busy ignored; RX_D_VLD during SEND ignored; RST asserted mid-WAIT_RSP -> all outputs 0 immediately; next command frames correctly.
